// File: rtl/sim_end_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_end_monitor_if : RAM read port and signature stream bundle       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sim_end_monitor_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_ack_i;
    logic [31:0]           mem_data_i;
    logic                  sig_valid_o;
    logic [31:0]           sig_data_o;
    logic                  sig_last_o;
    logic                  sig_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o,
        input  mem_ack_i, mem_data_i, sig_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, sig_valid_o, sig_data_o, sig_last_o,
        output mem_ack_i, mem_data_i, sig_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/sim_end_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sim_end_monitor : classifies the CPU halt and dumps the signature    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sim_end_monitor #(
    parameter int unsigned           FINISH_DELAY   = 4,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BEGIN_ADDR = 32'h8000_0000,
    parameter int unsigned           MAX_SIG_WORDS  = 4096,
    parameter bit                    TEST_MODE      = 1'b1
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_n_i,
    input  wire logic                  halted_i,
    input  wire logic                  looping_i,
    input  wire logic [ADDR_WIDTH-1:0] trap_mcause_i,
    input  wire logic [ADDR_WIDTH-1:0] sig_begin_i,
    input  wire logic [ADDR_WIDTH-1:0] sig_end_i,
    sim_end_monitor_if.master          bus,
    output logic                       done_o,
    output logic                       exit_code_o,
    output logic [1:0]                 end_cause_o,
    output logic [15:0]                word_count_o
);

    localparam int unsigned           c_CNT_W      = (FINISH_DELAY > 0) ? $clog2(FINISH_DELAY + 1) : 1;
    localparam logic [c_CNT_W-1:0]    c_CNT_LOAD   = c_CNT_W'(FINISH_DELAY);
    localparam logic [ADDR_WIDTH:0]   c_MAX_WORDS  = (ADDR_WIDTH+1)'(MAX_SIG_WORDS);
    localparam logic [ADDR_WIDTH:0]   c_WORD_BYTES = (ADDR_WIDTH+1)'(4);
    localparam logic [ADDR_WIDTH:0]   c_ROUND_UP   = (ADDR_WIDTH+1)'(3);
    localparam logic [1:0]            c_CAUSE_LOOP = 2'd0;
    localparam logic [1:0]            c_CAUSE_BRK  = 2'd1;
    localparam logic [1:0]            c_CAUSE_EXC  = 2'd2;
    localparam logic [1:0]            c_CAUSE_SIG  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_CLASSIFY = 3'd2,
        S_READ     = 3'd3,
        S_OUT      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  r_state, w_state_next;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                    r_looping, r_break;
    logic [ADDR_WIDTH-1:0]   r_begin, r_end;
    logic                    w_latch;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
    logic [31:0]             r_data, w_data_next;
    logic [15:0]             r_wcnt, w_wcnt_next;
    logic                    r_done, w_done_next;
    logic                    r_exit, w_exit_next;
    logic [1:0]              r_cause, w_cause_next;

    logic [ADDR_WIDTH-1:0]   w_end_rel;
    logic [ADDR_WIDTH:0]     w_addr_plus4;
    logic                    w_at_end;
    logic [ADDR_WIDTH:0]     w_span;
    logic [ADDR_WIDTH:0]     w_words;
    logic                    w_sig_err;
    logic                    w_unused_mcause;

    assign w_unused_mcause = ^{trap_mcause_i[ADDR_WIDTH-1:4], trap_mcause_i[2:0]};

    // Extra top bit keeps the end-of-region compares free of wraparound.
    assign w_end_rel    = r_end - RAM_BEGIN_ADDR;
    assign w_addr_plus4 = {1'b0, r_addr} + c_WORD_BYTES;
    assign w_at_end     = (w_addr_plus4 >= {1'b0, w_end_rel});
    assign w_span       = {1'b0, r_end} - {1'b0, r_begin};
    assign w_words      = (w_span + c_ROUND_UP) >> 2;
    assign w_sig_err    = (r_end <= r_begin) || (r_begin < RAM_BEGIN_ADDR) ||
                          (r_begin[1:0] != 2'b00) || (w_words > c_MAX_WORDS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_wcnt_next  = r_wcnt;
        w_done_next  = r_done;
        w_exit_next  = r_exit;
        w_cause_next = r_cause;

        case (r_state)
            S_IDLE: begin
                if (halted_i) begin
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!halted_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_latch      = 1'b1;
                    w_state_next = S_CLASSIFY;
                end else begin
                    w_cnt_next = r_cnt - c_CNT_W'(1);
                end
            end
            S_CLASSIFY: begin
                if (r_looping) begin
                    if (!TEST_MODE) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_exit_next  = 1'b0;
                        w_cause_next = c_CAUSE_LOOP;
                    end else if (w_sig_err) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_exit_next  = 1'b1;
                        w_cause_next = c_CAUSE_SIG;
                    end else begin
                        w_addr_next  = r_begin - RAM_BEGIN_ADDR;
                        w_cause_next = c_CAUSE_LOOP;
                        w_state_next = S_READ;
                    end
                end else begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_exit_next  = 1'b1;
                    w_cause_next = r_break ? c_CAUSE_BRK : c_CAUSE_EXC;
                end
            end
            S_READ: begin
                if (bus.mem_ack_i) begin
                    w_data_next  = bus.mem_data_i;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.sig_ready_i) begin
                    w_addr_next = w_addr_plus4[ADDR_WIDTH-1:0];
                    w_wcnt_next = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
                    if (w_at_end) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_exit_next  = 1'b0;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_looping <= 1'b0;
            r_break   <= 1'b0;
            r_begin   <= '0;
            r_end     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_wcnt    <= '0;
            r_done    <= 1'b0;
            r_exit    <= 1'b0;
            r_cause   <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_wcnt  <= w_wcnt_next;
            r_done  <= w_done_next;
            r_exit  <= w_exit_next;
            r_cause <= w_cause_next;
            if (w_latch) begin
                r_looping <= looping_i;
                r_break   <= trap_mcause_i[3];
                r_begin   <= sig_begin_i;
                r_end     <= sig_end_i;
            end
        end
    end

    assign bus.mem_req_o   = (r_state == S_READ);
    assign bus.mem_addr_o  = r_addr;
    assign bus.sig_valid_o = (r_state == S_OUT);
    assign bus.sig_data_o  = r_data;
    assign bus.sig_last_o  = (r_state == S_OUT) && w_at_end;

    assign done_o       = r_done;
    assign exit_code_o  = r_exit;
    assign end_cause_o  = r_cause;
    assign word_count_o = r_wcnt;

endmodule
`default_nettype wire

// File: doc/sim_end_monitor.md
SIM_END_MONITOR -- requirements
Module: sim_end_monitor

Interface
REQ-001 Parameter FINISH_DELAY, default 4: number of consecutive halted cycles before classification starts.
REQ-002 Parameter ADDR_WIDTH, default 32: width of all address and mcause buses.
REQ-003 Parameter RAM_BEGIN_ADDR, default 32'h8000_0000: CPU address of RAM word 0.
REQ-004 Parameter MAX_SIG_WORDS, default 4096: largest signature dump allowed, in 32-bit words.
REQ-005 Parameter TEST_MODE, default 1: 1 = dump the signature on a looping end; 0 = report only.
REQ-006 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n_i  in  1  asynchronous, active-low reset.
REQ-008 halted_i  in  1  CPU is in the halted state.
REQ-009 looping_i  in  1  halt was caused by a looping instruction.
REQ-010 trap_mcause_i  in  ADDR_WIDTH  one-hot trap cause; bit 3 = breakpoint.
REQ-011 sig_begin_i, sig_end_i  in  ADDR_WIDTH each  signature bounds as CPU addresses (x1, x2).
REQ-012 mem_req_o  out  1  RAM read request; mem_addr_o  out  ADDR_WIDTH  RAM-relative byte address.
REQ-013 mem_ack_i  in  1  read complete; mem_data_i  in  32  read data, valid when mem_ack_i=1.
REQ-014 sig_valid_o  out  1; sig_data_o  out  32; sig_last_o  out  1; sig_ready_i  in  1.
REQ-015 done_o  out  1  end reached; exit_code_o  out  1  0 = pass, 1 = fail.
REQ-016 end_cause_o  out  2  0 = LOOP, 1 = BREAK, 2 = EXC, 3 = SIG_ERR; word_count_o  out  16  words emitted.

Function
REQ-017 The FSM SHALL have the states IDLE, DELAY, CLASSIFY, READ, OUT and DONE.
REQ-018 IDLE: when halted_i=1, SHALL load the counter with FINISH_DELAY and enter DELAY.
REQ-019 DELAY: halted_i=0 SHALL return the FSM to IDLE (abort); otherwise the counter SHALL decrement each cycle.
REQ-020 DELAY: when the counter is 0, SHALL latch looping_i, trap_mcause_i, sig_begin_i and sig_end_i, then enter CLASSIFY; FINISH_DELAY=0 SHALL enter CLASSIFY on the next cycle.
REQ-021 CLASSIFY SHALL take exactly one cycle and select the cause by priority: looping -> LOOP; else mcause[3] -> BREAK; else -> EXC.
REQ-022 BREAK or EXC SHALL go to DONE with exit_code=1.
REQ-023 LOOP with TEST_MODE=0 SHALL go to DONE with exit_code=0.
REQ-024 LOOP with TEST_MODE=1 SHALL go to DONE with cause SIG_ERR and exit_code=1 if any of these hold:
- end <= begin;
- begin < RAM_BEGIN_ADDR;
- begin[1:0] != 0;
- ceil((end-begin)/4) > MAX_SIG_WORDS.
REQ-025 Otherwise the block SHALL set the address to begin-RAM_BEGIN_ADDR (ADDR_WIDTH modulo arithmetic) and enter READ.
REQ-026 READ: mem_req_o=1 and mem_addr_o stable until mem_ack_i=1; on ack, SHALL capture mem_data_i and enter OUT.
REQ-027 OUT: sig_valid_o=1, with sig_data_o and sig_last_o held stable until sig_ready_i=1.
REQ-028 On an OUT handshake the address SHALL advance by 4 and word_count_o SHALL increment.
REQ-029 After the handshake, the FSM SHALL enter DONE (exit_code=0) if the new address >= end-RAM_BEGIN_ADDR, otherwise READ.
REQ-030 sig_last_o SHALL be 1 only on the word whose address+4 >= end-RAM_BEGIN_ADDR.
REQ-031 Each word SHALL require at least 2 cycles (READ then OUT); there SHALL be no read-ahead and at most one outstanding request.
REQ-032 mem_req_o and sig_valid_o SHALL never be asserted in the same cycle.
REQ-033 DONE SHALL be sticky: done_o=1, exit_code_o and end_cause_o held, all inputs ignored until reset.
REQ-034 In READ and OUT, changes on halted_i, looping_i, trap_mcause_i and the bounds SHALL have no effect, because the latched copies are used.
REQ-035 A mem_ack_i outside READ, or sig_ready_i outside OUT, SHALL be ignored.
REQ-036 word_count_o SHALL saturate at 16'hFFFF.

Reset
REQ-037 rst_n_i=0 SHALL, asynchronously and in any state (including mid-READ with a request outstanding), force:
- state = IDLE;
- mem_req_o, sig_valid_o, sig_last_o, done_o, exit_code_o = 0;
- end_cause_o = 0, word_count_o = 0, mem_addr_o = 0, sig_data_o = 0, counter = 0.
REQ-038 After rst_n_i rises, the FSM SHALL leave IDLE no earlier than the first rising edge on which halted_i=1.

Verification
REQ-039 Pass dump: halted, looping, begin=8000_0100, end=8000_010C, ack in 1 cycle, ready=1 -> reads at 100, 104, 108; last on the third word; done=1, exit=0, word_count=3.
REQ-040 Breakpoint: looping=0, mcause=0000_0008 -> done=1, cause=BREAK, exit=1, no mem_req_o, done exactly FINISH_DELAY+2 cycles after halted_i rises.
REQ-041 Abort: halted_i high for 2 cycles then low, with FINISH_DELAY=4 -> state returns to IDLE, done stays 0; a later halted_i restarts the full count.
REQ-042 Backpressure: sig_ready_i low for 5 cycles on word 2 -> sig_data_o stable, no new mem_req_o, word_count unchanged until the handshake.
REQ-043 Signature error: looping, begin=8000_0200, end=8000_0200 -> cause=SIG_ERR, exit=1, word_count=0.
REQ-044 Reset in READ: rst_n_i low while mem_req_o=1 -> all outputs 0 in the same cycle; a re-run after release produces a correct dump.
